// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side operands, downstream stage results and hazard outputs
interface hazard_scoreboard_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
);
  logic                    id_valid_i;
  logic [REG_AW-1:0]       id_rs1_i;
  logic [REG_AW-1:0]       id_rs2_i;
  logic                    id_use_rs1_i;
  logic                    id_use_rs2_i;
  logic [REG_AW-1:0]       id_rd_i;
  logic                    id_wb_en_i;
  logic                    id_is_load_i;
  logic [XLEN-1:0]         id_op1_i;
  logic [XLEN-1:0]         id_op2_i;
  logic [DEPTH*XLEN-1:0]   stage_data_i;
  logic                    flush_i;
  logic                    stall_o;
  logic                    issue_o;
  logic [XLEN-1:0]         op1_o;
  logic [XLEN-1:0]         op2_o;
  logic [15:0]             stall_cnt_o;
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_rd_i,
           id_wb_en_i, id_is_load_i, id_op1_i, id_op2_i, stage_data_i, flush_i,
    input  stall_o, issue_o, op1_o, op2_o, stall_cnt_o
  );
  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_rd_i,
           id_wb_en_i, id_is_load_i, id_op1_i, id_op2_i, stage_data_i, flush_i,
    output stall_o, issue_o, op1_o, op2_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination tags, forwards from the youngest producer,
// raises load-use stalls, honours decode flush and counts stall cycles.
module hazard_scoreboard #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  hazard_scoreboard_if.slave bus
);
  logic              v_q  [1:DEPTH];
  logic              v_d  [1:DEPTH];
  logic [REG_AW-1:0] rd_q [1:DEPTH];
  logic [REG_AW-1:0] rd_d [1:DEPTH];
  logic              ld_q [1:DEPTH];
  logic              ld_d [1:DEPTH];
  logic [15:0]       stall_cnt_q;
  logic [15:0]       stall_cnt_d;
  logic [XLEN-1:0]   op1;
  logic [XLEN-1:0]   op2;
  logic              st1;
  logic              st2;
  logic              stall;
  logic              issue;
  always_comb begin
    op1 = bus.id_op1_i;
    op2 = bus.id_op2_i;
    st1 = 1'b0;
    st2 = 1'b0;
    // Walk oldest to youngest so the lowest matching entry is the one left standing
    for (int k = DEPTH; k >= 1; k--) begin
      if (bus.id_use_rs1_i && bus.id_rs1_i != '0 && v_q[k] && rd_q[k] == bus.id_rs1_i) begin
        op1 = bus.stage_data_i[k*XLEN-1 -: XLEN];
        st1 = ld_q[k] && (k < LOAD_STAGE);
      end
      if (bus.id_use_rs2_i && bus.id_rs2_i != '0 && v_q[k] && rd_q[k] == bus.id_rs2_i) begin
        op2 = bus.stage_data_i[k*XLEN-1 -: XLEN];
        st2 = ld_q[k] && (k < LOAD_STAGE);
      end
    end
    stall = bus.id_valid_i && !bus.flush_i && (st1 || st2);
    issue = bus.id_valid_i && !stall && !bus.flush_i;
    // Bubbles only clear v; rd/ld hold so idle entries do not toggle
    v_d[1]  = issue && bus.id_wb_en_i && bus.id_rd_i != '0;
    rd_d[1] = issue ? bus.id_rd_i : rd_q[1];
    ld_d[1] = issue ? bus.id_is_load_i : ld_q[1];
    for (int k = 2; k <= DEPTH; k++) begin
      v_d[k]  = v_q[k-1];
      rd_d[k] = rd_q[k-1];
      ld_d[k] = ld_q[k-1];
    end
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      v_q         <= '{default: 1'b0};
      rd_q        <= '{default: '0};
      ld_q        <= '{default: 1'b0};
      stall_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      rd_q        <= rd_d;
      ld_q        <= ld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign bus.stall_o     = stall;
  assign bus.issue_o     = issue;
  assign bus.op1_o       = op1;
  assign bus.op2_o       = op2;
  assign bus.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random checks against a queue-of-instructions model
module tb_hazard_scoreboard;
  localparam int XLEN = 32, REG_AW = 5, DEPTH = 3, LOAD_STAGE = 2;
  typedef struct packed {logic v; logic [4:0] rd; logic ld;} rec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  rec_t q[$];
  int unsigned cnt_m = 0;
  int total = 0;
  int bad = 0;
  logic        e_stall, e_issue;
  logic [31:0] e_op1, e_op2;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH)) bus ();
  hazard_scoreboard #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE))
    dut (.clk_i(clk), .reset_i(reset_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wb, input logic ld, input logic fl);
    bus.id_valid_i   = v;
    bus.id_rs1_i     = rs1;
    bus.id_rs2_i     = rs2;
    bus.id_use_rs1_i = u1;
    bus.id_use_rs2_i = u2;
    bus.id_rd_i      = rd;
    bus.id_wb_en_i   = wb;
    bus.id_is_load_i = ld;
    bus.flush_i      = fl;
    bus.id_op1_i     = $urandom;
    bus.id_op2_i     = $urandom;
    for (int s = 0; s < DEPTH; s++) bus.stage_data_i[s*XLEN +: XLEN] = $urandom;
  endtask
  function automatic logic [31:0] slice(input int age);
    return bus.stage_data_i[age*XLEN +: XLEN];
  endfunction
  task automatic predict();
    logic l1 = 1'b0, l2 = 1'b0;
    e_op1 = bus.id_op1_i;
    e_op2 = bus.id_op2_i;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].v && bus.id_use_rs1_i && bus.id_rs1_i != 0 && q[i].rd == bus.id_rs1_i) begin
        e_op1 = slice(i);
        l1 = q[i].ld && (i + 1 < LOAD_STAGE);
      end
      if (q[i].v && bus.id_use_rs2_i && bus.id_rs2_i != 0 && q[i].rd == bus.id_rs2_i) begin
        e_op2 = slice(i);
        l2 = q[i].ld && (i + 1 < LOAD_STAGE);
      end
    end
    e_stall = bus.id_valid_i && !bus.flush_i && (l1 || l2);
    e_issue = bus.id_valid_i && !bus.flush_i && !e_stall;
  endtask
  task automatic cycle(input string tag);
    #1;
    predict();
    chk({tag, "_stall"}, bus.stall_o, e_stall);
    chk({tag, "_issue"}, bus.issue_o, e_issue);
    chk({tag, "_op1"}, bus.op1_o, e_op1);
    chk({tag, "_op2"}, bus.op2_o, e_op2);
    chk({tag, "_cnt"}, bus.stall_cnt_o, cnt_m);
    @(posedge clk);
    q.push_front(rec_t'{e_issue && bus.id_wb_en_i && bus.id_rd_i != 0, bus.id_rd_i, bus.id_is_load_i});
    if (q.size() > DEPTH) void'(q.pop_back());
    if (e_stall && cnt_m != 16'hFFFF) cnt_m++;
    @(negedge clk);
  endtask
  initial begin
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_issue", bus.issue_o, 1);
    chk("rst_op1", bus.op1_o, bus.id_op1_i);
    chk("rst_cnt", bus.stall_cnt_o, 0);
    reset_n = 1'b1;
    @(negedge clk);
    // ALU -> ALU forwarding from entry 1
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    cycle("t1a");
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
    bus.stage_data_i[XLEN-1:0] = 32'h1234;
    #1;
    chk("t1_op1", bus.op1_o, 32'h1234);
    cycle("t1b");
    // Load-use: one stall cycle, then forward from entry 2
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    cycle("t2a");
    drive(1, 0, 7, 0, 1, 9, 1, 0, 0);
    #1;
    chk("t2_stall", bus.stall_o, 1);
    chk("t2_issue", bus.issue_o, 0);
    cycle("t2b");
    drive(1, 0, 7, 0, 1, 9, 1, 0, 0);
    #1;
    chk("t2_op2", bus.op2_o, slice(1));
    chk("t2_issue2", bus.issue_o, 1);
    cycle("t2c");
    // Youngest producer wins, then entry 3 alone
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cycle("t3a");
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cycle("t3b");
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("t3_e1", bus.op1_o, slice(0));
    cycle("t3c");
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("t3_e2", bus.op1_o, slice(1));
    cycle("t3d");
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("t3_e3", bus.op1_o, slice(2));
    cycle("t3e");
    // x0 never forwards; unused source never stalls
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("t4a");
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("t4_x0", bus.op1_o, bus.id_op1_i);
    cycle("t4b");
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0);
    cycle("t4c");
    drive(1, 0, 4, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t4_nouse", bus.stall_o, 0);
    cycle("t4d");
    // Flush overrides a load-use stall
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0);
    cycle("t5a");
    drive(1, 8, 0, 1, 0, 0, 0, 0, 1);
    #1;
    chk("t5_stall", bus.stall_o, 0);
    chk("t5_issue", bus.issue_o, 0);
    cycle("t5b");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("t5c");
    // Asynchronous reset in the middle of a stall
    drive(1, 0, 0, 0, 0, 10, 1, 1, 0);
    cycle("t6a");
    drive(1, 10, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("t6_pre", bus.stall_o, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_stall", bus.stall_o, 0);
    chk("t6_cnt", bus.stall_cnt_o, 0);
    chk("t6_op1", bus.op1_o, bus.id_op1_i);
    q.delete();
    cnt_m = 0;
    @(negedge clk);
    reset_n = 1'b1;
    // Counter saturation, preloaded close to the top
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    cnt_m = 16'hFFFD;
    @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      drive(1, 7, 0, 1, 0, 7, 1, 1, 0);
      cycle("sat");
    end
    chk("sat_hold", bus.stall_cnt_o, 16'hFFFF);
    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      cycle("rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
